// File: rtl/cpu_pkg.sv
// Shared core definitions: bus width codes, reset PC, prefetch state encoding
// and the fetch-entry record passed from the prefetcher to decode.
package cpu_pkg;

    localparam logic [1:0] MW_BYTE = 2'h0;
    localparam logic [1:0] MW_HALF = 2'h1;
    localparam logic [1:0] MW_WORD = 2'h2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0800_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } pf_state_e;

    // pc is held at full 32 bits; narrower address widths are zero-extended.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        thumb;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with clear, occupancy count
// and wrap-around pointers. DEPTH must be a power of two.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear,
    input  logic             i_push,
    input  fetch_entry_t     i_push_entry,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~i_clear;
    assign w_pop  = i_pop & ~i_clear & (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/cpu_prefetch_unit.sv
// Instruction prefetch front end: streams ARM words or Thumb halfwords into a FIFO for decode.
// Define PREFETCH_STATS_EN to build the fetch/discard counters; otherwise both ports read 0.
module cpu_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              flush_thumb,
    output logic              instr_valid,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_thumb,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_width,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ok,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       discard_cnt
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    pf_state_e         r_state;
    pf_state_e         w_state_next;
    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] w_fpc_next;
    logic              r_t_mode;
    logic [ADDR_W-1:0] r_old_addr;
    logic              r_old_thumb;
    logic [ADDR_W-1:0] w_flush_fpc;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_bus_thumb;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_flush_fpc = flush_thumb ? {flush_pc[ADDR_W-1:1], 1'b0}
                                     : {flush_pc[ADDR_W-1:2], 2'b00};

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid & instr_ready & ~flush;

    always_comb begin
        w_state_next = r_state;
        w_fpc_next   = r_fpc;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count < DEPTH_C) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ok && !flush) begin
                    w_push     = 1'b1;
                    w_fpc_next = r_fpc + (r_t_mode ? ADDR_W'(2) : ADDR_W'(4));
                    if ((w_count + CNT_W'(1) - CNT_W'(w_pop)) < DEPTH_C) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (mem_ok) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Bus requests are never withdrawn: an unfinished one must be drained in S_DISCARD.
        if (flush) begin
            w_fpc_next = w_flush_fpc;
            if (r_state != S_IDLE && !mem_ok) begin
                w_state_next = S_DISCARD;
            end else begin
                w_state_next = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_fpc       <= RESET_PC;
            r_t_mode    <= 1'b0;
            r_old_addr  <= RESET_PC;
            r_old_thumb <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fpc   <= w_fpc_next;
            if (flush) begin
                r_t_mode <= flush_thumb;
            end
            if (flush && r_state == S_REQ && !mem_ok) begin
                r_old_addr  <= r_fpc;
                r_old_thumb <= r_t_mode;
            end
        end
    end

    assign w_bus_thumb = (r_state == S_DISCARD) ? r_old_thumb : r_t_mode;
    assign mem_read    = (r_state != S_IDLE);
    assign mem_addr    = (r_state == S_DISCARD) ? r_old_addr : r_fpc;
    assign mem_width   = w_bus_thumb ? MW_HALF : MW_WORD;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = 32'(r_fpc);
        w_push_entry.data  = r_t_mode ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
        w_push_entry.thumb = r_t_mode;
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (flush),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign instr_data  = w_head.data;
    assign instr_pc    = w_head.pc[ADDR_W-1:0];
    assign instr_thumb = w_head.thumb;

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_discard_cnt;
    logic        w_discard;

    assign w_discard = mem_ok && ((r_state == S_DISCARD) || (r_state == S_REQ && flush));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_cnt   <= 32'h0;
            r_discard_cnt <= 32'h0;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 32'h1;
            end
            if (w_discard) begin
                r_discard_cnt <= r_discard_cnt + 32'h1;
            end
        end
    end

    assign fetch_cnt   = r_fetch_cnt;
    assign discard_cnt = r_discard_cnt;
`else
    assign fetch_cnt   = 32'h0;
    assign discard_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// Self-checking bench for cpu_prefetch_unit: directed scenarios then randomized traffic,
// checked against a queue-based model of the fetch stream.
module tb_cpu_prefetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [31:0] flush_pc;
    logic        flush_thumb;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_thumb;
    logic        instr_ready;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_ok;
    logic [31:0] fetch_cnt;
    logic [31:0] discard_cnt;

    cpu_prefetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .flush_thumb (flush_thumb),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_thumb (instr_thumb),
        .instr_ready (instr_ready),
        .mem_addr    (mem_addr),
        .mem_width   (mem_width),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .mem_ok      (mem_ok),
        .fetch_cnt   (fetch_cnt),
        .discard_cnt (discard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        thumb;
    } ent_t;

    // Reference model: expected FIFO contents and fetch stream.
    ent_t        q[$];
    logic [31:0] m_fpc;
    logic        m_thumb;
    logic        m_disc_pend;
    logic [31:0] m_disc_addr;
    logic        m_disc_thumb;
    logic        m_just_reset;
    int          m_prev_size;
    logic        m_prev_flush;
    int unsigned m_fetches;
    int unsigned m_discards;

    // Stimulus knobs and observations.
    int unsigned k_waits;
    bit          k_rand_waits;
    int unsigned k_ready_pct;
    int unsigned k_flush_pm;
    bit          k_fixed_data;
    logic [31:0] k_data;
    int unsigned wcnt;
    logic [31:0] ok_addr_log[$];
    logic [1:0]  ok_width_log[$];
    logic [31:0] pop_pc_log[$];

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc        = 32'h0800_0000;
        m_thumb      = 1'b0;
        m_disc_pend  = 1'b0;
        m_disc_addr  = 32'h0;
        m_disc_thumb = 1'b0;
        m_just_reset = 1'b1;
        m_prev_size  = 0;
        m_prev_flush = 1'b0;
        m_fetches    = 0;
        m_discards   = 0;
        wcnt         = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model, cross the edge.
    task automatic step(input bit do_flush, input logic [31:0] fpc_in, input bit fth_in);
        ent_t e;
        int   sz_before;
        bit   pop;
        bit   ok;
        bit   idle_allowed;

        chk("instr_valid", instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr_data", instr_data, q[0].data);
            chk("instr_thumb", instr_thumb, q[0].thumb);
        end
        if (mem_read) begin
            chk("mem_addr", mem_addr, m_disc_pend ? m_disc_addr : m_fpc);
            chk("mem_width", mem_width, (m_disc_pend ? m_disc_thumb : m_thumb) ? 2'h1 : 2'h2);
        end
        // Fetch may only pause once the FIFO has been seen full and no flush restarted it.
        idle_allowed = !m_prev_flush && (m_prev_size == DEPTH || q.size() == DEPTH);
        if (!m_just_reset && !idle_allowed) begin
            chk("mem_read_active", mem_read, 1'b1);
        end
`ifdef PREFETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, m_fetches);
        chk("discard_cnt", discard_cnt, m_discards);
`else
        chk("fetch_cnt_tied", fetch_cnt, 32'h0);
        chk("discard_cnt_tied", discard_cnt, 32'h0);
`endif

        instr_ready = ($urandom_range(99) < k_ready_pct);
        if (do_flush) begin
            flush       = 1'b1;
            flush_pc    = fpc_in;
            flush_thumb = fth_in;
        end else begin
            flush       = ($urandom_range(999) < k_flush_pm);
            flush_pc    = $urandom;
            flush_thumb = 1'($urandom_range(1));
        end
        ok = 1'b0;
        if (mem_read) begin
            if (wcnt >= k_waits) begin
                ok   = 1'b1;
                wcnt = 0;
                if (k_rand_waits) k_waits = $urandom_range(3);
            end else begin
                wcnt++;
            end
        end
        mem_ok    = ok;
        mem_rdata = k_fixed_data ? k_data : $urandom;
        if (ok) begin
            ok_addr_log.push_back(mem_addr);
            ok_width_log.push_back(mem_width);
        end

        sz_before = q.size();
        pop = (q.size() != 0) && instr_ready && !flush;
        if (pop) begin
            pop_pc_log.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (ok) begin
            if (m_disc_pend || flush) begin
                m_discards++;
                m_disc_pend = 1'b0;
            end else begin
                e.pc    = m_fpc;
                e.data  = m_thumb ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
                e.thumb = m_thumb;
                q.push_back(e);
                m_fpc = m_fpc + (m_thumb ? 32'd2 : 32'd4);
                m_fetches++;
            end
        end
        if (flush) begin
            q.delete();
            if (mem_read && !ok && !m_disc_pend) begin
                m_disc_pend  = 1'b1;
                m_disc_addr  = m_fpc;
                m_disc_thumb = m_thumb;
            end
            m_fpc   = flush_thumb ? (flush_pc & ~32'h1) : (flush_pc & ~32'h3);
            m_thumb = flush_thumb;
        end
        m_prev_size  = sz_before;
        m_prev_flush = flush;
        m_just_reset = 1'b0;

        @(posedge clk);
        #1;
        mem_ok = 1'b0;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        flush_thumb = 1'b0;
        instr_ready = 1'b0;
        mem_ok      = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0800_0000);
        chk("rst_mem_width", mem_width, 2'h2);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_discard_cnt", discard_cnt, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlog;
        n_checks     = 0;
        n_errors     = 0;
        k_waits      = 0;
        k_rand_waits = 1'b0;
        k_ready_pct  = 0;
        k_flush_pm   = 0;
        k_fixed_data = 1'b0;
        k_data       = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait fill with decode stalled.
        for (int i = 0; i < 10; i++) step(0, 32'h0, 1'b0);
        chk("t1_nfetch", ok_addr_log.size(), 4);
        if (ok_addr_log.size() >= 4) begin
            chk("t1_addr0", ok_addr_log[0], 32'h0800_0000);
            chk("t1_addr1", ok_addr_log[1], 32'h0800_0004);
            chk("t1_addr2", ok_addr_log[2], 32'h0800_0008);
            chk("t1_addr3", ok_addr_log[3], 32'h0800_000C);
        end
        chk("t1_mem_read_low", mem_read, 1'b0);
        chk("t1_head_pc", instr_pc, 32'h0800_0000);

        // Drain with decode always ready: one instruction per cycle.
        k_ready_pct = 100;
        pop_pc_log.delete();
        for (int i = 0; i < 20; i++) step(0, 32'h0, 1'b0);
        chk("t2_npops", pop_pc_log.size(), 20);
        if (pop_pc_log.size() > 0) chk("t2_first_pc", pop_pc_log[0], 32'h0800_0000);
        for (int i = 1; i < pop_pc_log.size(); i++) begin
            chk("t2_pc_step", pop_pc_log[i] - pop_pc_log[i-1], 32'd4);
        end

        // Flush to Thumb while a 3-wait-state request is in flight.
        k_ready_pct  = 0;
        k_waits      = 3;
        k_fixed_data = 1'b1;
        k_data       = 32'hABCD_1234;
        for (int i = 0; i < 50 && !(mem_read && wcnt == 1); i++) step(0, 32'h0, 1'b0);
        chk("t3_inflight", mem_read, 1'b1);
        ok_addr_log.delete();
        ok_width_log.delete();
        nlog = int'(mem_addr);
        step(1, 32'h0800_0101, 1'b1);
        for (int i = 0; i < 80 && ok_addr_log.size() < 3; i++) step(0, 32'h0, 1'b0);
        chk("t3_nfetch", ok_addr_log.size() >= 3, 1'b1);
        if (ok_addr_log.size() >= 3) begin
            chk("t3_old_addr", ok_addr_log[0], 32'(nlog));
            chk("t3_new_addr", ok_addr_log[1], 32'h0800_0100);
            chk("t3_new_width", ok_width_log[1], 2'h1);
            chk("t3_next_addr", ok_addr_log[2], 32'h0800_0102);
        end
`ifdef PREFETCH_STATS_EN
        chk("t3_discard_cnt", discard_cnt, 32'h1);
`endif
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1'b0);
        chk("t5_valid", instr_valid, 1'b1);
        chk("t5_thumb_data", instr_data, 32'h0000_1234);
        chk("t5_thumb_flag", instr_thumb, 1'b1);

        // Flush landing on the same cycle as mem_ok and a pop.
        k_waits      = 0;
        k_ready_pct  = 100;
        k_fixed_data = 1'b0;
        for (int i = 0; i < 20 && !(mem_read && instr_valid); i++) step(0, 32'h0, 1'b0);
        chk("t4_setup", mem_read && instr_valid, 1'b1);
        nlog = ok_addr_log.size();
        step(1, 32'h0800_1000, 1'b0);
        chk("t4_memok_seen", ok_addr_log.size(), 32'(nlog + 1));
        chk("t4_valid_after_flush", instr_valid, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 32'h0, 1'b0);

        // Reset asserted in the middle of a request.
        k_waits     = 3;
        k_ready_pct = 0;
        for (int i = 0; i < 50 && !(mem_read && wcnt == 1); i++) step(0, 32'h0, 1'b0);
        chk("t6_inflight", mem_read, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t6_async_drop", mem_read, 1'b0);
        chk("t6_valid_drop", instr_valid, 1'b0);
        do_reset();
        for (int i = 0; i < 5 && !mem_read; i++) step(0, 32'h0, 1'b0);
        chk("t6_restart_read", mem_read, 1'b1);
        chk("t6_restart_addr", mem_addr, 32'h0800_0000);

        // Address wrap in Thumb mode, then randomized traffic.
        k_rand_waits = 1'b1;
        k_ready_pct  = 50;
        step(1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 12; i++) step(0, 32'h0, 1'b0);
        k_ready_pct = 65;
        k_flush_pm  = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) k_ready_pct = $urandom_range(20, 100);
            step(0, 32'h0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
